sram_ctrl_fsm: RTL and testbench

Parametrised, timed asynchronous-SRAM controller and the successor to the single-cycle pass-through controller. A req/ready handshake accepts one read or write at a time. Registered FSM outputs drive address, ce_n, oe_n and we_n with programmable wait states and explicit write address-setup and data-hold phases. Sits between the SRAM tester logic and the external SRAM pins.

---
 rtl/sram_ctrl_pkg.sv | 24 ++
 rtl/sram_ctrl_fsm_if.sv | 36 +++
 rtl/sram_dio_buf.sv | 34 +++
 rtl/sram_ctrl_fsm.sv | 172 +++++++++++++++++
 tb/tb_sram_ctrl_fsm.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - state encoding and counter sizing for the timed SRAM controller
// Contents:
//   state_t : controller states IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD
//   cnt_w() : wait-counter width, clog2(max(RD_WAIT, WR_WAIT)), never below 1 bit
package sram_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD       = 3'd1,
      ST_WR_SETUP = 3'd2,
      ST_WR_PULSE = 3'd3,
      ST_WR_HOLD  = 3'd4
   } state_t;

   // The counter is loaded with WAIT-1, so clog2(max) bits are enough.
   // A wait of 1 still needs a 1-bit counter so the vector is never zero width.
   function automatic int cnt_w(input int rd_wait, input int wr_wait);
      int m;
      m = (rd_wait > wr_wait) ? rd_wait : wr_wait;
      if (m <= 2) return 1;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/sram_ctrl_fsm_if.sv
// rtl/sram_ctrl_fsm_if.sv - requester-side handshake bundle of the SRAM controller
// Signals:
//   req        : request strobe, accepted only while ready=1
//   rw         : 1=read, 0=write
//   addr       : request address
//   data_f2s   : write data
//   ready      : controller idle
//   data_s2f_r : registered read data
//   rvalid     : one-cycle pulse, data_s2f_r updated
//   wdone      : one-cycle pulse, write cycle complete
// Modports: master (requester), slave (controller).
interface sram_ctrl_fsm_if #(
   parameter int ADDR_W = 19,
   parameter int DATA_W = 8
);

   logic              req;
   logic              rw;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data_f2s;
   logic              ready;
   logic [DATA_W-1:0] data_s2f_r;
   logic              rvalid;
   logic              wdone;

   modport master (
      output req, rw, addr, data_f2s,
      input  ready, data_s2f_r, rvalid, wdone
   );

   modport slave (
      input  req, rw, addr, data_f2s,
      output ready, data_s2f_r, rvalid, wdone
   );

endinterface

// File: rtl/sram_dio_buf.sv
// rtl/sram_dio_buf.sv - tri-state driver and read-capture register for the SRAM data bus
// Ports:
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_oe             : drive io_dio with i_wdata when 1, release to Z when 0
//   i_wdata          : data to drive
//   i_cap            : capture io_dio into o_rdata on this edge
//   o_rdata          : captured read data, held until the next capture
//   io_dio           : SRAM data pins
module sram_dio_buf #(
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_oe,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_cap,
   output logic [DATA_W-1:0] o_rdata,
   inout  wire  [DATA_W-1:0] io_dio
);

   logic [DATA_W-1:0] r_rdata;

   assign io_dio  = i_oe ? i_wdata : {DATA_W{1'bz}};
   assign o_rdata = r_rdata;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_rdata <= '0;
      end else if (i_cap) begin
         r_rdata <= io_dio;
      end
   end

endmodule

// File: rtl/sram_ctrl_fsm.sv
// rtl/sram_ctrl_fsm.sv - timed asynchronous-SRAM controller with wait states and write setup/hold
// Ports:
//   i_clk     : system clock, rising edge
//   i_reset_n : asynchronous active-low reset
//   host      : requester handshake (sram_ctrl_fsm_if.slave)
//   o_ad      : SRAM address, registered, stable for the whole transaction
//   o_ce_n    : SRAM chip enable, active-low, registered
//   o_oe_n    : SRAM output enable, active-low, registered
//   o_we_n    : SRAM write enable, active-low, registered
//   io_dio    : SRAM data bus
module sram_ctrl_fsm
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_W  = 19,
   parameter int DATA_W  = 8,
   parameter int RD_WAIT = 2,
   parameter int WR_WAIT = 2
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   sram_ctrl_fsm_if.slave    host,
   output logic [ADDR_W-1:0] o_ad,
   output logic              o_ce_n,
   output logic              o_oe_n,
   output logic              o_we_n,
   inout  wire  [DATA_W-1:0] io_dio
);

   localparam int            CW      = cnt_w(RD_WAIT, WR_WAIT);
   localparam logic [CW-1:0] RD_LOAD = CW'(RD_WAIT - 1);
   localparam logic [CW-1:0] WR_LOAD = CW'(WR_WAIT - 1);

   state_t            r_state,  w_state_nxt;
   logic [CW-1:0]     r_cnt,    w_cnt_nxt;
   logic [ADDR_W-1:0] r_ad,     w_ad_nxt;
   logic              r_ce_n,   w_ce_n_nxt;
   logic              r_oe_n,   w_oe_n_nxt;
   logic              r_we_n,   w_we_n_nxt;
   logic              r_dio_oe, w_dio_oe_nxt;
   logic [DATA_W-1:0] r_wdata,  w_wdata_nxt;
   logic              r_rvalid, w_rvalid_nxt;
   logic              r_wdone,  w_wdone_nxt;
   logic              w_cap;
   logic [DATA_W-1:0] w_rdata;

   sram_dio_buf #(.DATA_W(DATA_W)) u_dio (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_oe      (r_dio_oe),
      .i_wdata   (r_wdata),
      .i_cap     (w_cap),
      .o_rdata   (w_rdata),
      .io_dio    (io_dio)
   );

   assign host.ready      = (r_state == ST_IDLE);
   assign host.data_s2f_r = w_rdata;
   assign host.rvalid     = r_rvalid;
   assign host.wdone      = r_wdone;

   assign o_ad   = r_ad;
   assign o_ce_n = r_ce_n;
   assign o_oe_n = r_oe_n;
   assign o_we_n = r_we_n;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_ad     <= '0;
         r_ce_n   <= 1'b1;
         r_oe_n   <= 1'b1;
         r_we_n   <= 1'b1;
         r_dio_oe <= 1'b0;
         r_wdata  <= '0;
         r_rvalid <= 1'b0;
         r_wdone  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_ad     <= w_ad_nxt;
         r_ce_n   <= w_ce_n_nxt;
         r_oe_n   <= w_oe_n_nxt;
         r_we_n   <= w_we_n_nxt;
         r_dio_oe <= w_dio_oe_nxt;
         r_wdata  <= w_wdata_nxt;
         r_rvalid <= w_rvalid_nxt;
         r_wdone  <= w_wdone_nxt;
      end
   end

   // Every pin is computed one cycle ahead and registered, so the SRAM sees
   // glitch-free strobes that change only on clock edges.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_ad_nxt     = r_ad;
      w_ce_n_nxt   = r_ce_n;
      w_oe_n_nxt   = r_oe_n;
      w_we_n_nxt   = r_we_n;
      w_dio_oe_nxt = r_dio_oe;
      w_wdata_nxt  = r_wdata;
      w_rvalid_nxt = 1'b0;
      w_wdone_nxt  = 1'b0;
      w_cap        = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (host.req) begin
               w_ad_nxt   = host.addr;
               w_ce_n_nxt = 1'b0;
               if (host.rw) begin
                  w_state_nxt = ST_RD;
                  w_oe_n_nxt  = 1'b0;
                  w_cnt_nxt   = RD_LOAD;
               end else begin
                  // Data goes on the bus together with ce_n, one cycle
                  // ahead of we_n, giving the address/data setup phase.
                  w_state_nxt  = ST_WR_SETUP;
                  w_dio_oe_nxt = 1'b1;
                  w_wdata_nxt  = host.data_f2s;
               end
            end
         end

         ST_RD: begin
            if (r_cnt == '0) begin
               w_cap        = 1'b1;
               w_rvalid_nxt = 1'b1;
               w_ce_n_nxt   = 1'b1;
               w_oe_n_nxt   = 1'b1;
               w_state_nxt  = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end

         ST_WR_SETUP: begin
            w_state_nxt = ST_WR_PULSE;
            w_we_n_nxt  = 1'b0;
            w_cnt_nxt   = WR_LOAD;
         end

         ST_WR_PULSE: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_WR_HOLD;
               w_we_n_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end

         ST_WR_HOLD: begin
            // Releasing the bus on the IDLE-entry edge guarantees a turnaround
            // cycle before any following read can pull oe_n low.
            w_wdone_nxt  = 1'b1;
            w_ce_n_nxt   = 1'b1;
            w_dio_oe_nxt = 1'b0;
            w_state_nxt  = ST_IDLE;
         end

         default: begin
            w_state_nxt  = ST_IDLE;
            w_ce_n_nxt   = 1'b1;
            w_oe_n_nxt   = 1'b1;
            w_we_n_nxt   = 1'b1;
            w_dio_oe_nxt = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_sram_ctrl_fsm.sv
// tb/tb_sram_ctrl_fsm.sv - self-checking bench for sram_ctrl_fsm (two parameter sets)
module tb_sram_ctrl_fsm;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;
   int   checks = 0;
   int   errors = 0;
   int   inv_err = 0;

   sram_ctrl_fsm_if #(.ADDR_W(19), .DATA_W(8))  if_a ();
   sram_ctrl_fsm_if #(.ADDR_W(19), .DATA_W(16)) if_b ();

   wire  [7:0]  dio_a;
   wire  [15:0] dio_b;
   logic [18:0] ad_a, ad_b;
   logic        ce_a, oe_a, we_a, ce_b, oe_b, we_b;

   sram_ctrl_fsm #(.ADDR_W(19), .DATA_W(8), .RD_WAIT(2), .WR_WAIT(2)) u_a (
      .i_clk(clk), .i_reset_n(reset_n), .host(if_a.slave),
      .o_ad(ad_a), .o_ce_n(ce_a), .o_oe_n(oe_a), .o_we_n(we_a), .io_dio(dio_a)
   );

   sram_ctrl_fsm #(.ADDR_W(19), .DATA_W(16), .RD_WAIT(1), .WR_WAIT(4)) u_b (
      .i_clk(clk), .i_reset_n(reset_n), .host(if_b.slave),
      .o_ad(ad_b), .o_ce_n(ce_b), .o_oe_n(oe_b), .o_we_n(we_b), .io_dio(dio_b)
   );

   // SRAM models: write while we_n low, read data presented while oe_n low
   logic [7:0]  mem_a [logic [18:0]];
   logic [15:0] mem_b [logic [18:0]];
   logic [7:0]  q_a = '0;
   logic [15:0] q_b = '0;

   always @(negedge clk) begin
      if (!ce_a && !we_a) mem_a[ad_a] = dio_a;
      if (mem_a.exists(ad_a)) q_a = mem_a[ad_a]; else q_a = '0;
      if (!ce_b && !we_b) mem_b[ad_b] = dio_b;
      if (mem_b.exists(ad_b)) q_b = mem_b[ad_b]; else q_b = '0;
   end

   assign dio_a = (!ce_a && !oe_a) ? q_a : 8'hzz;
   assign dio_b = (!ce_b && !oe_b) ? q_b : 16'hzzzz;

   always @(negedge clk) begin
      if (reset_n) begin
         if (!oe_a && u_a.r_dio_oe) inv_err++;
         if (!oe_b && u_b.r_dio_oe) inv_err++;
         if (if_a.rvalid && if_a.wdone) inv_err++;
         if (if_b.rvalid && if_b.wdone) inv_err++;
      end
   end

   // observation mux over the two instances
   logic        sel = 1'b0;
   logic [18:0] s_ad;
   logic        s_ce, s_oe, s_we, s_rvalid, s_wdone, s_ready, s_drv;
   logic [15:0] s_rd, s_dio;

   always_comb begin
      if (sel) begin
         s_ad = ad_b; s_ce = ce_b; s_oe = oe_b; s_we = we_b;
         s_rvalid = if_b.rvalid; s_wdone = if_b.wdone; s_ready = if_b.ready;
         s_rd = if_b.data_s2f_r; s_dio = dio_b; s_drv = u_b.r_dio_oe;
      end else begin
         s_ad = ad_a; s_ce = ce_a; s_oe = oe_a; s_we = we_a;
         s_rvalid = if_a.rvalid; s_wdone = if_a.wdone; s_ready = if_a.ready;
         s_rd = {8'h00, if_a.data_s2f_r}; s_dio = {8'h00, dio_a}; s_drv = u_a.r_dio_oe;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic s, input logic r, input logic w,
                        input logic [18:0] a, input logic [15:0] d);
      if (!s) begin
         if_a.req = r; if_a.rw = w; if_a.addr = a; if_a.data_f2s = d[7:0];
      end else begin
         if_b.req = r; if_b.rw = w; if_b.addr = a; if_b.data_f2s = d;
      end
   endtask

   typedef struct {
      logic        sel;      // 0: RD_WAIT=2/WR_WAIT=2/8-bit, 1: RD_WAIT=1/WR_WAIT=4/16-bit
      logic        rw;
      logic [18:0] addr;
      logic [15:0] data;
      logic        poke;     // pulse a read req to 0x00001 during WR_PULSE
      int          exp_lo;   // cycles oe_n (read) or we_n (write) low
      int          exp_lat;  // done pulse seen after edge E0+exp_lat
      int          exp_drv;  // cycles the controller drives dio
      logic [15:0] exp_rd;
   } vec_t;

   vec_t vecs [13];

   function automatic vec_t mk(input logic s, input logic r, input logic [18:0] a,
                               input logic [15:0] d, input logic p, input int lo,
                               input int lat, input int drv, input logic [15:0] rd);
      vec_t v;
      v.sel = s; v.rw = r; v.addr = a; v.data = d; v.poke = p;
      v.exp_lo = lo; v.exp_lat = lat; v.exp_drv = drv; v.exp_rd = rd;
      return v;
   endfunction

   // Called at a negedge; returns at the negedge of the done cycle so the
   // next vector can issue back-to-back.
   task automatic run_vec(input int i);
      vec_t v;
      int   n, lo, drv, lat, bad_ad, bad_dio, idle_bad;
      logic done;
      v = vecs[i];
      sel = v.sel;
      #1;
      n = 0;
      while (!s_ready && n < 50) begin
         @(negedge clk); #1; n++;
      end
      check($sformatf("v%0d ready before req", i), {31'd0, s_ready}, 32'd1);
      drive(v.sel, 1'b1, v.rw, v.addr, v.data);
      @(posedge clk);
      lo = 0; drv = 0; lat = -1; bad_ad = 0; bad_dio = 0; done = 1'b0;
      for (int k = 1; k <= 20 && !done; k++) begin
         @(negedge clk);
         if (k == 1) drive(v.sel, 1'b0, ~v.rw, ~v.addr, ~v.data);
         if (v.poke && k == 2) drive(v.sel, 1'b1, 1'b1, 19'h00001, 16'h0000);
         if (v.poke && k == 3) drive(v.sel, 1'b0, 1'b1, 19'h00001, 16'h0000);
         #1;
         if (s_drv) begin
            drv++;
            if (s_dio !== v.data) bad_dio++;
         end
         if (v.rw ? !s_oe : !s_we) lo++;
         if (s_ad !== v.addr) bad_ad++;
         if (s_rvalid || s_wdone) begin
            done = 1'b1;
            lat = k - 1;
            check($sformatf("v%0d pulse kind", i), {30'd0, s_rvalid, s_wdone},
                  v.rw ? 32'd2 : 32'd1);
            check($sformatf("v%0d ready/ce/drv at done", i), {29'd0, s_ready, s_ce, s_drv}, 32'd6);
         end
      end
      check($sformatf("v%0d latency", i), lat, v.exp_lat);
      check($sformatf("v%0d strobe low cycles", i), lo, v.exp_lo);
      check($sformatf("v%0d bus drive cycles", i), drv, v.exp_drv);
      check($sformatf("v%0d ad changes", i), bad_ad, 0);
      check($sformatf("v%0d dio wrong value", i), bad_dio, 0);
      if (v.rw) check($sformatf("v%0d read data", i), {16'd0, s_rd}, {16'd0, v.exp_rd});
      if (v.poke) begin
         idle_bad = 0;
         for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            if (!s_ce || s_rvalid || s_wdone || !s_ready) idle_bad++;
         end
         check($sformatf("v%0d busy req ignored", i), idle_bad, 0);
      end
   endtask

   initial begin
      int n;
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      reset_n = 1'b1;
      #2 reset_n = 1'b0;

      vecs[0]  = mk(0, 0, 19'h12345, 16'h00A5, 0, 2, 4, 4, 16'h0000);
      vecs[1]  = mk(0, 1, 19'h12345, 16'h0000, 0, 2, 2, 0, 16'h00A5);
      vecs[2]  = mk(0, 0, 19'h7FFFF, 16'h003C, 0, 2, 4, 4, 16'h0000);
      vecs[3]  = mk(0, 1, 19'h7FFFF, 16'h0000, 0, 2, 2, 0, 16'h003C);
      vecs[4]  = mk(0, 0, 19'h00100, 16'h0055, 1, 2, 4, 4, 16'h0000);
      vecs[5]  = mk(0, 1, 19'h12345, 16'h0000, 0, 2, 2, 0, 16'h00A5);
      vecs[6]  = mk(0, 1, 19'h00100, 16'h0000, 0, 2, 2, 0, 16'h0055);
      vecs[7]  = mk(0, 0, 19'h00000, 16'h00FF, 0, 2, 4, 4, 16'h0000);
      vecs[8]  = mk(0, 1, 19'h00000, 16'h0000, 0, 2, 2, 0, 16'h00FF);
      vecs[9]  = mk(1, 0, 19'h00010, 16'hBEEF, 0, 4, 6, 6, 16'h0000);
      vecs[10] = mk(1, 1, 19'h00010, 16'h0000, 0, 1, 1, 0, 16'hBEEF);
      vecs[11] = mk(1, 0, 19'h7FFFF, 16'h1234, 0, 4, 6, 6, 16'h0000);
      vecs[12] = mk(1, 1, 19'h7FFFF, 16'h0000, 0, 1, 1, 0, 16'h1234);

      // reset state of both instances
      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         check($sformatf("reset%0d ready", s), {31'd0, s_ready}, 32'd1);
         check($sformatf("reset%0d ce/oe/we", s), {29'd0, s_ce, s_oe, s_we}, 32'd7);
         check($sformatf("reset%0d rvalid/wdone", s), {30'd0, s_rvalid, s_wdone}, 32'd0);
         check($sformatf("reset%0d ad", s), {13'd0, s_ad}, 32'd0);
         check($sformatf("reset%0d data_s2f_r", s), {16'd0, s_rd}, 32'd0);
         check($sformatf("reset%0d bus released", s), {31'd0, s_drv}, 32'd0);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 13; i++) run_vec(i);

      // reset asserted in the middle of a write pulse
      sel = 1'b0;
      @(negedge clk); #1;
      drive(1'b0, 1'b1, 1'b0, 19'h00200, 16'h0099);
      @(posedge clk);
      n = 0;
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 19'h00200, 16'h0099);
      #1;
      while (s_we && n < 10) begin
         @(negedge clk); #1; n++;
      end
      check("midwrite we_n low reached", {31'd0, s_we}, 32'd0);
      reset_n = 1'b0;
      #1;
      check("midwrite reset ce/oe/we", {29'd0, s_ce, s_oe, s_we}, 32'd7);
      check("midwrite reset bus released", {31'd0, s_drv}, 32'd0);
      check("midwrite reset rvalid/wdone", {30'd0, s_rvalid, s_wdone}, 32'd0);
      check("midwrite reset ad", {13'd0, s_ad}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk); #1;
      check("after reset ready", {31'd0, s_ready}, 32'd1);
      check("after reset ce_n", {31'd0, s_ce}, 32'd1);

      check("invariant violations", inv_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
